csa_operand_collector: RTL and testbench
========================================

CSA_OPERAND_COLLECTOR -- requirements
Module: csa_operand_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the bit width of each operand and each output operand port.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_data, input, WIDTH bits: incoming operand.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operand this cycle.
REQ-007 SHALL have port flush, input, 1 bit: close a partial bundle (present only with CSA_COLLECT_FLUSH_EN).
REQ-008 SHALL have ports a, b, c, d, each output, WIDTH bits: the four bundled operands for the downstream 4-operand carry-save adder.
REQ-009 SHALL have port out_count, output, 3 bits: number of real operands in the bundle (1-4).
REQ-010 SHALL have port out_valid, output, 1 bit: bundle on a/b/c/d/out_count is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the bundle.

Function
REQ-012 SHALL implement a two-state FSM, COLLECT and FULL, with a 2-bit slot index idx (0-3).
REQ-013 SHALL drive in_ready=1 iff the state is COLLECT and rst=0, and out_valid=1 iff the state is FULL.
REQ-014 SHALL, on an accept (in_valid & in_ready), store in_data into slot idx (0->a, 1->b, 2->c, 3->d) and increment idx.
REQ-015 SHALL, on the accept with idx=3, enter FULL, so out_valid rises in the cycle after the edge at which the 4th operand is accepted (latency 1), with out_count=4.
REQ-016 SHALL hold a, b, c, d and out_count stable while in FULL, regardless of in_valid or flush.
REQ-017 SHALL, in FULL with out_ready=1, return to COLLECT at that edge, clear all slots to 0, set idx=0 and out_count=0.
REQ-018 SHALL NOT accept input in FULL, including the cycle in which the bundle drains; maximum throughput is one bundle per 5 cycles.
REQ-019 SHALL keep a, b, c, d at their stored values (unfilled slots 0) during COLLECT, with out_valid=0.
REQ-020 SHALL ignore in_data whenever in_valid=0, leaving slot contents unchanged.

Reset
REQ-021 SHALL, when rst=1 at a rising edge, set state=COLLECT, idx=0, a=b=c=d=0, out_count=0 and out_valid=0, overriding any simultaneous accept, flush or drain.
REQ-022 SHALL, for reset asserted mid-bundle (COLLECT with idx>0, or FULL), discard the partial or full bundle with no output transaction.
REQ-023 SHALL drive in_ready=0 while rst=1 and in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL compile the flush feature in only when macro CSA_COLLECT_FLUSH_EN is defined.
REQ-025 SHALL, with CSA_COLLECT_FLUSH_EN defined and in COLLECT: for flush=1 with idx>0 and no accept, enter FULL with out_count=idx and unfilled slots 0.
REQ-026 SHALL, with CSA_COLLECT_FLUSH_EN defined: for flush=1 coinciding with an accept, store the operand first, then enter FULL with out_count=idx+1.
REQ-027 SHALL, with CSA_COLLECT_FLUSH_EN defined: ignore flush when idx=0 with no accept, and ignore flush in FULL.
REQ-028 SHALL, without CSA_COLLECT_FLUSH_EN, omit the flush port entirely, so that only full 4-operand bundles are produced and out_count is always 4 when out_valid=1.

Verification
REQ-029 Reset then 4 accepts 3,5,9,15 with out_ready=0 -> a=3, b=5, c=9, d=15, out_count=4, out_valid=1 the cycle after the 4th accept, held 3 cycles, in_ready=0 throughout.
REQ-030 FULL with out_ready=1 for one cycle -> out_valid=0, a=b=c=d=0 and in_ready=1 next cycle; back-to-back stream of 8 operands -> 2 bundles, 10 cycles minimum.
REQ-031 Gaps in in_valid (valid 1,0,0,1,1,0,1 with data 1..7 driven every cycle) -> bundle is 1,4,5,7, not the values driven while in_valid=0.
REQ-032 With CSA_COLLECT_FLUSH_EN: accept 6,2 then flush -> a=6, b=2, c=d=0, out_count=2; flush with an accept of 7 after 6 -> a=6, b=7, c=d=0, out_count=2; flush at idx=0 -> no output.
REQ-033 rst asserted after 2 accepts, and separately rst asserted in FULL with out_ready=1 -> all outputs 0, no out_valid pulse, next 4 accepts form a fresh bundle starting at slot a.

Source files
------------

// File: rtl/csa_operand_collector.sv
// Packs a stream of operands into 4-wide bundles (a..d) for a 4-operand CSA; CSA_COLLECT_FLUSH_EN adds a flush port that closes partial bundles.
// Latency: bundle valid the cycle after the edge that accepts its last operand.
// Backpressure: in_ready drops while a bundle is held; bundle held until out_ready, no input taken in that cycle.
module csa_operand_collector #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef CSA_COLLECT_FLUSH_EN
    input  logic             flush,
`endif
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [2:0]       out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] c_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic [2:0]       count_nxt;
    logic             accept;
    logic             close_req;

    assign in_ready  = (state == COLLECT) && !rst;
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;

    // A flush only closes a bundle that will hold at least one operand.
`ifdef CSA_COLLECT_FLUSH_EN
    assign close_req = flush && (accept || (idx != 2'd0));
`else
    assign close_req = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_nxt     = a;
        b_nxt     = b;
        c_nxt     = c;
        d_nxt     = d;
        count_nxt = out_count;
        case (state)
            COLLECT: begin
                if (accept) begin
                    case (idx)
                        2'd0:    a_nxt = in_data;
                        2'd1:    b_nxt = in_data;
                        2'd2:    c_nxt = in_data;
                        default: d_nxt = in_data;
                    endcase
                    idx_nxt = idx + 2'd1;
                end
                if (accept && (idx == 2'd3)) begin
                    state_nxt = FULL;
                    count_nxt = 3'd4;
                end else if (close_req) begin
                    state_nxt = FULL;
                    count_nxt = accept ? ({1'b0, idx} + 3'd1) : {1'b0, idx};
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nxt = COLLECT;
                    idx_nxt   = 2'd0;
                    a_nxt     = '0;
                    b_nxt     = '0;
                    c_nxt     = '0;
                    d_nxt     = '0;
                    count_nxt = 3'd0;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= 2'd0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            out_count <= 3'd0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            c         <= c_nxt;
            d         <= d_nxt;
            out_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_csa_operand_collector.sv
// Scoreboard bench for csa_operand_collector: stimulus pushes expected bundles, a negedge monitor checks them.
module tb_csa_operand_collector;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
`ifdef CSA_COLLECT_FLUSH_EN
    logic         flush;
`endif
    logic [W-1:0] a, b, c, d;
    logic [2:0]   out_count;
    logic         out_valid;
    logic         out_ready;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cyc = 0;
    logic [31:0] exp_q[$];

    csa_operand_collector #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
`ifdef CSA_COLLECT_FLUSH_EN
        .flush    (flush),
`endif
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bun(input logic [W-1:0] ea, input logic [W-1:0] eb,
                                        input logic [W-1:0] ec, input logic [W-1:0] ed,
                                        input logic [2:0] n);
        return {13'd0, ea, eb, ec, ed, n};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bundle checked on every valid cycle, retired on the handshake cycle.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_bundle: got %0h expected none", bun(a, b, c, d, out_count));
            end else begin
                chk("bundle", bun(a, b, c, d, out_count), exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    hs_cyc = cyc;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic chk_empty(input string nm);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_slots"}, bun(a, b, c, d, out_count), 0);
    endtask

    initial begin
        int t0;
        logic [6:0] vpat;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
`ifdef CSA_COLLECT_FLUSH_EN
        flush = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk_empty("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Full bundle, held with out_ready low while junk is offered.
        exp_q.push_back(bun(3, 5, 9, 15, 4));
        send(3);
        send(5);
        send(9);
        chk("pre_full_valid", out_valid, 0);
        send(15);
        chk("latency_valid", out_valid, 1);
        in_valid = 1'b1;
        in_data = 4'ha;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        chk_empty("drained");
        chk("drained_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Back-to-back stream: two bundles in ten cycles.
        out_ready = 1'b1;
        exp_q.push_back(bun(1, 2, 3, 4, 4));
        exp_q.push_back(bun(5, 6, 7, 8, 4));
        t0 = cyc;
        for (int i = 1; i <= 8; i++) send(W'(i));
        drain();
        chk("stream_cycles", hs_cyc + 1 - t0, 10);

        // Gaps in in_valid: data is driven every cycle but only valid beats land.
        vpat = 7'b1011001;
        exp_q.push_back(bun(1, 4, 5, 7, 4));
        for (int i = 0; i < 7; i++) begin
            in_valid = vpat[i];
            in_data = W'(i + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset after two accepts discards the partial bundle.
        send(10);
        send(11);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_empty("mid_rst");
        @(posedge clk);
        #1;
        exp_q.push_back(bun(1, 2, 3, 4, 4));
        for (int i = 1; i <= 4; i++) send(W'(i));
        drain();

        // Reset in FULL while out_ready is high: no transaction.
        exp_q.push_back(bun(9, 8, 7, 6, 4));
        for (int i = 9; i >= 6; i--) send(W'(i));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk_empty("full_rst");
        chk("full_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        exp_q.push_back(bun(2, 4, 6, 8, 4));
        for (int i = 1; i <= 4; i++) send(W'(2 * i));
        drain();

`ifdef CSA_COLLECT_FLUSH_EN
        exp_q.push_back(bun(6, 2, 0, 0, 2));
        send(6);
        send(2);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        drain();

        exp_q.push_back(bun(6, 7, 0, 0, 2));
        send(6);
        flush = 1'b1;
        send(7);
        flush = 1'b0;
        drain();

        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idx0_valid", out_valid, 0);
        chk("flush_idx0_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
